multicycle_control: RTL and testbench

- Multi-cycle FSM controller for the MIPS datapath: sequences fetch, decode, execute, memory and writeback over several clocks, with one shared instruction/data memory.
- Supported instructions: R-type add/sub/and/or/slt, lw, sw, beq.
- Waits on a memory ready handshake, pulses `illegal` on unsupported encodings, and counts retired instructions.
- `op` and `funct` come from the instruction register, which is stable from DECODE until the next fetch.

---
 rtl/multicycle_control_if.sv | 12 +
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Shared instruction/data memory handshake between the controller and the memory.
// Latency: none, wires only.
// Backpressure: the master holds mem_req until the slave returns mem_ready.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback over one shared memory.
// Latency (zero-wait memory): R-type 4, beq 3, lw 5, sw 4, illegal 3 cycles; outputs decode from state.
// Backpressure: mem_req held with stable address/direction until mem_ready; each wait cycle adds one.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           ALUOP,
  output logic                 regdst,
  output logic                 WBData,
  output logic                 regWrite,
  output logic                 instr_done,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    TRAP      = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t cur;

  // Only the five supported R-type functions are legal; everything else traps.
  function automatic logic r_legal(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
  endfunction

  function automatic logic [3:0] r_aluop(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // State register, next-state selection and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= IDLE;
      instr_count <= '0;
    end else begin
      if (instr_done) instr_count <= instr_count + CNT_ONE;
      case (cur)
        IDLE:      cur <= FETCH;
        FETCH:     if (mem.mem_ready) cur <= DECODE;
        DECODE: begin
          if (op == OP_LW || op == OP_SW)            cur <= MEM_ADDR;
          else if (op == OP_RTYPE && r_legal(funct)) cur <= EXEC_R;
          else if (op == OP_BEQ)                     cur <= BRANCH;
          else                                       cur <= TRAP;
        end
        MEM_ADDR:  cur <= op[3] ? MEM_WRITE : MEM_READ;
        MEM_READ:  if (mem.mem_ready) cur <= MEM_WB;
        MEM_WB:    cur <= FETCH;
        MEM_WRITE: if (mem.mem_ready) cur <= FETCH;
        EXEC_R:    cur <= R_WB;
        R_WB:      cur <= FETCH;
        BRANCH:    cur <= FETCH;
        TRAP:      cur <= FETCH;
        default:   cur <= IDLE;
      endcase
    end
  end

  // Datapath controls decoded from the current state; ready/zero only qualify enables.
  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    ALUOP       = ALU_ADD;
    regdst      = 1'b0;
    WBData      = 1'b0;
    regWrite    = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (cur)
      IDLE: ALUOP = 4'b0000;
      FETCH: begin
        // PC+4 is computed alongside the fetch and committed with the IR.
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        ir_write    = mem.mem_ready;
        pc_write    = mem.mem_ready;
      end
      // Speculative branch target into ALUOut while the register file is read.
      DECODE: alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
      end
      MEM_WB: begin
        regWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
        instr_done  = mem.mem_ready;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        ALUOP     = r_aluop(funct);
      end
      R_WB: begin
        regWrite   = 1'b1;
        regdst     = 1'b1;
        WBData     = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        ALUOP      = ALU_SUB;
        pc_src     = 1'b1;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a per-instruction phase model of the controller.
// Latency: one check of every control output and the counter per clock.
// Backpressure: memory wait cycles are planned per instruction and driven on mem_ready.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       ALUOP;
  logic             regdst, WBData, regWrite, instr_done, illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  multicycle_control_if mbus ();

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem         (mbus),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .ALUOP       (ALUOP),
    .regdst      (regdst),
    .WBData      (WBData),
    .regWrite    (regWrite),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       req, we, iord, irw, pcw, pcs, asa;
    logic [1:0] asb;
    logic [3:0] aluop;
    logic       rd, wb, rw, done, ill;
  } ctl_t;

  typedef struct packed {
    ctl_t       exp;
    logic       rdy;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
  } cyc_t;

  typedef enum {K_R, K_LW, K_SW, K_BEQ, K_ILL} kind_t;

  ctl_t obs;
  assign obs = {state, mbus.mem_req, mbus.mem_we, mbus.iord, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, ALUOP, regdst, WBData, regWrite, instr_done, illegal};

  cyc_t plan[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, want);
    end
  endtask

  function automatic ctl_t base(input logic [3:0] st);
    ctl_t c = '0;
    c.st    = st;
    c.aluop = 4'b0010;
    return c;
  endfunction

  function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h23) return K_LW;
    if (o == 6'h2B) return K_SW;
    if (o == 6'h04) return K_BEQ;
    if (o == 6'h00 && (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A)) return K_R;
    return K_ILL;
  endfunction

  function automatic logic [3:0] alu_for(input logic [5:0] f);
    case (f)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic push(input ctl_t c, input logic rdy, input logic [5:0] o, input logic [5:0] f, input logic z);
    cyc_t p;
    p.exp = c;
    p.rdy = rdy;
    p.op  = o;
    p.fn  = f;
    p.z   = z;
    plan.push_back(p);
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, from its class and planned waits.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z, input int wf, input int wm);
    ctl_t c;
    kind_t k = classify(o, f);
    c = base(4'd1); c.req = 1'b1; c.asb = 2'b01;
    repeat (wf) push(c, 1'b0, 6'($urandom), 6'($urandom), rnd1());
    c.irw = 1'b1; c.pcw = 1'b1;
    push(c, 1'b1, 6'($urandom), 6'($urandom), rnd1());
    c = base(4'd2); c.asb = 2'b11;
    push(c, rnd1(), o, f, rnd1());
    case (k)
      K_R: begin
        c = base(4'd7); c.asa = 1'b1; c.aluop = alu_for(f);
        push(c, rnd1(), o, f, rnd1());
        c = base(4'd8); c.rw = 1'b1; c.rd = 1'b1; c.wb = 1'b1; c.done = 1'b1;
        push(c, rnd1(), o, f, rnd1());
      end
      K_LW, K_SW: begin
        c = base(4'd3); c.asa = 1'b1; c.asb = 2'b10;
        push(c, rnd1(), o, f, rnd1());
        c = base((k == K_LW) ? 4'd4 : 4'd6); c.req = 1'b1; c.iord = 1'b1; c.we = (k == K_SW);
        repeat (wm) push(c, 1'b0, o, f, rnd1());
        c.done = (k == K_SW);
        push(c, 1'b1, o, f, rnd1());
        if (k == K_LW) begin
          c = base(4'd5); c.rw = 1'b1; c.done = 1'b1;
          push(c, rnd1(), o, f, rnd1());
        end
      end
      K_BEQ: begin
        c = base(4'd9); c.asa = 1'b1; c.aluop = 4'b0110; c.pcs = 1'b1; c.pcw = z; c.done = 1'b1;
        push(c, rnd1(), o, f, z);
      end
      default: begin
        c = base(4'd10); c.ill = 1'b1;
        push(c, rnd1(), o, f, rnd1());
      end
    endcase
  endtask

  task automatic do_cycle(input cyc_t p);
    @(negedge clk);
    mbus.mem_ready = p.rdy;
    op             = p.op;
    funct          = p.fn;
    zero           = p.z;
    #1;
    check($sformatf("ctl_st%0d", p.exp.st), 32'(obs), 32'(p.exp));
    check("instr_count", 32'(instr_count), 32'(exp_cnt));
    if (p.exp.done) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  // Runs n planned cycles (all of them when n < 0).
  task automatic run(input int n);
    int done_n = 0;
    while (plan.size() > 0 && (n < 0 || done_n < n)) begin
      do_cycle(plan.pop_front());
      done_n++;
    end
  endtask

  task automatic idle_cycle();
    build_idle();
    run(-1);
  endtask

  task automatic build_idle();
    ctl_t c = '0;
    push(c, rnd1(), 6'($urandom), 6'($urandom), rnd1());
  endtask

  function automatic logic [5:0] rand_illegal_op();
    logic [5:0] o;
    do o = 6'($urandom); while (o == 6'h00 || o == 6'h23 || o == 6'h2B || o == 6'h04);
    return o;
  endfunction

  function automatic logic [5:0] rand_illegal_fn();
    logic [5:0] f;
    do f = 6'($urandom); while (classify(6'h00, f) != K_ILL);
    return f;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;

    rst_n          = 1'b0;
    op             = '0;
    funct          = '0;
    zero           = 1'b0;
    mbus.mem_ready = 1'b0;
    #3;
    check("reset_ctl", 32'(obs), 32'd0);
    check("reset_cnt", 32'(instr_count), 32'd0);
    #4 rst_n = 1'b1;
    idle_cycle();

    // Directed: add, lw with waits, sw, beq taken/not taken, two illegal encodings.
    build(6'h00, 6'h20, 1'b0, 0, 0); run(-1);
    build(6'h23, 6'h00, 1'b0, 3, 2); run(-1);
    build(6'h2B, 6'h00, 1'b0, 0, 1); run(-1);
    build(6'h04, 6'h00, 1'b1, 0, 0); run(-1);
    build(6'h04, 6'h00, 1'b0, 1, 0); run(-1);
    build(6'h3F, 6'h00, 1'b0, 0, 0); run(-1);
    build(6'h00, 6'h27, 1'b0, 0, 0); run(-1);

    // Random mix; counter is narrow so it wraps several times.
    for (int i = 0; i < 200; i++) begin
      int sel = $urandom_range(0, 9);
      int wf  = $urandom_range(0, 3);
      int wm  = $urandom_range(0, 3);
      logic z = rnd1();
      case (sel)
        0, 1, 2: build(6'h00, fns[$urandom_range(0, 4)], z, wf, wm);
        3, 4:    build(6'h23, 6'($urandom), z, wf, wm);
        5:       build(6'h2B, 6'($urandom), z, wf, wm);
        6, 7:    build(6'h04, 6'($urandom), z, wf, wm);
        8:       build(rand_illegal_op(), 6'($urandom), z, wf, wm);
        default: build(6'h00, rand_illegal_fn(), z, wf, wm);
      endcase
      run(-1);
    end

    // Asynchronous reset while a load waits in MEM_READ.
    build(6'h23, 6'h00, 1'b0, 0, 5);
    run(4);
    plan.delete();
    #1 rst_n = 1'b0;
    #1;
    check("midreset_state", 32'(state), 32'd0);
    check("midreset_req", 32'(mbus.mem_req), 32'd0);
    check("midreset_ctl", 32'(obs), 32'd0);
    check("midreset_cnt", 32'(instr_count), 32'd0);
    exp_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle_cycle();
    build(6'h00, 6'h2A, 1'b0, 0, 0); run(-1);
    idle_check_after();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Next cycle after the final retirement must be a fresh fetch with the updated count.
  task automatic idle_check_after();
    ctl_t c = base(4'd1);
    c.req = 1'b1;
    c.asb = 2'b01;
    push(c, 1'b0, 6'($urandom), 6'($urandom), rnd1());
    run(-1);
  endtask

endmodule
